mult_unit: RTL and testbench
============================

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have port: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  in  1  request, sampled only in IDLE; driven from decode-to-execute mult.
REQ-004 SHALL have port: flush  in  1  abandon current operation (execute-stage flush).
REQ-005 SHALL have port: a  in  32  operand 1 (rdat1 path).
REQ-006 SHALL have port: b  in  32  operand 2 (rdat2 path).
REQ-007 SHALL have port: half  in  1  0 = low 32 product bits, 1 = high 32 bits (mult_half).
REQ-008 SHALL have port: signed_a  in  1  treat a as two's complement (mult_signed_a).
REQ-009 SHALL have port: signed_b  in  1  treat b as two's complement (mult_signed_b).
REQ-010 SHALL have port: busy  out  1  high in CALC and SIGN; used as execute-stage stall.
REQ-011 SHALL have port: done  out  1  single-cycle pulse, result valid.
REQ-012 SHALL have port: result  out  32  selected product half, held until the next accepted start.

Function
REQ-013 SHALL implement states IDLE, CALC, SIGN, DONE (radix-2 shift-add, one multiplier bit per cycle).
REQ-014 IDLE: start=1 and flush=0 -> capture |a|, |b|, half, negate flag (neg_a XOR neg_b) into registers; go to CALC.
REQ-015 Magnitude rule: |x| = -x when signed_x=1 and x[31]=1, else x; 0x80000000 signed yields magnitude 0x80000000 unsigned.
REQ-016 CALC: 64-bit accumulator adds shifted multiplicand when current multiplier LSB=1; exactly 32 iterations via 6-bit counter, then SIGN.
REQ-017 SIGN: accumulator two's-complement negated (64-bit) when negate flag set; result register loaded with [63:32] if half else [31:0]; go to DONE.
REQ-018 DONE: done=1 for exactly that cycle; busy=0; unconditionally to IDLE; start in DONE is ignored.
REQ-019 Latency: start sampled at edge 0 -> done high in cycle 34 (32 CALC + SIGN + DONE).
REQ-020 start while busy SHALL be ignored; operand inputs are don't-care outside the IDLE capture cycle.
REQ-021 flush=1 in any state -> IDLE at next edge, no done pulse, result unchanged; flush and start together in IDLE -> stay IDLE.
REQ-022 Arithmetic SHALL be exact modulo 2^64 for all sign combinations (mul, mulh, mulhsu, mulhu).

Reset
REQ-023 rst=1 SHALL asynchronously force state=IDLE, busy=0, done=0, result=0, accumulator, counter and operand registers=0.
REQ-024 rst asserted mid-CALC SHALL abort the operation; no done pulse after rst deasserts until a new start.

Configuration
REQ-025 Macro MULT_EARLY_EXIT_EN defined: in CALC, when the remaining (post-shift) multiplier register is zero, go to SIGN after that cycle regardless of counter.
REQ-026 MULT_EARLY_EXIT_EN undefined: always 32 CALC cycles (fixed latency 34); results identical in both builds.

Structure
REQ-027 mult_state_t enum (IDLE, CALC, SIGN, DONE) and constant MULT_ITERS=32 SHALL live in common_types_pkg; word_t reused for a, b, result.
REQ-028 Single flat module; no sub-module.

Verification
REQ-029 a=7, b=0xFFFFFFFD, signed_a=signed_b=1, half=0 -> done in cycle 34, result=0xFFFFFFEB, busy high cycles 1-33.
REQ-030 a=b=0x80000000, both signed, half=1 -> result=0x40000000.
REQ-031 a=b=0xFFFFFFFF, unsigned, half=1 -> 0xFFFFFFFE; signed_a=1, signed_b=0, half=1 -> 0xFFFFFFFF.
REQ-032 start, flush=1 at cycle 10 -> busy=0 from cycle 11, no done; new start at cycle 12 (a=3, b=5) -> result=15 at cycle 46.
REQ-033 rst pulse in cycle 5 of CALC -> all outputs 0 immediately, no done afterwards; start during DONE ignored.
REQ-034 MULT_EARLY_EXIT_EN: b=0 -> done cycle 3, result 0; b=1, a=9 -> done cycle 3, result 9; build without it -> same values at cycle 34.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types and constants for the iterative multiplier.
package common_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] dword_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    localparam int MULT_ITERS = 32;

    // Two's-complement magnitude; 0x80000000 signed maps onto itself read as unsigned.
    function automatic word_t magnitude(input word_t x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mult_unit.sv
// Radix-2 shift-add 32x32 multiplier (mul/mulh/mulhsu/mulhu) with sign fix-up.
// Define MULT_EARLY_EXIT_EN to leave CALC as soon as the remaining multiplier is zero.
module mult_unit
    import common_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  logic  flush,
    input  word_t a,
    input  word_t b,
    input  logic  half,
    input  logic  signed_a,
    input  logic  signed_b,
    output logic  busy,
    output logic  done,
    output word_t result
);

    mult_state_t state_q;
    dword_t      acc_q, mcand_q;
    word_t       mplier_q;
    logic [5:0]  cnt_q;
    logic        neg_q, half_q, busy_q, done_q;
    word_t       result_q;

    dword_t      acc_d, mcand_d, acc_signed;
    word_t       mplier_d, result_d;
    logic        calc_last;

    always_comb begin
        acc_d      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d    = mcand_q << 1;
        mplier_d   = mplier_q >> 1;
        calc_last  = (cnt_q == 6'(MULT_ITERS - 1));
`ifdef MULT_EARLY_EXIT_EN
        calc_last  = calc_last || (mplier_d == '0);
`endif
        acc_signed = neg_q ? (~acc_q + 64'd1) : acc_q;
        result_d   = half_q ? acc_signed[63:32] : acc_signed[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            half_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                // Abandon without touching result; a flushed op never pulses done.
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            mcand_q  <= {32'd0, magnitude(a, signed_a)};
                            mplier_q <= magnitude(b, signed_b);
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            half_q   <= half;
                            neg_q    <= (signed_a & a[31]) ^ (signed_b & b[31]);
                            busy_q   <= 1'b1;
                            state_q  <= CALC;
                        end
                    end
                    CALC: begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        cnt_q    <= cnt_q + 6'd1;
                        if (calc_last) state_q <= SIGN;
                    end
                    SIGN: begin
                        result_q <= result_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed, table-driven bench for mult_unit plus flush/reset/ignored-start sequences.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        half = 1'b0;
    logic        signed_a = 1'b0;
    logic        signed_b = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mult_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .half     (half),
        .signed_a (signed_a),
        .signed_b (signed_b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        half;
        logic        sa;
        logic        sb;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [31:0] bv, input logic sb);
`ifdef MULT_EARLY_EXIT_EN
        logic [31:0] m;
        int n;
        m = (sb && bv[31]) ? (~bv + 32'd1) : bv;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n + 2;
`else
        return 34;
`endif
    endfunction

    // Issues one op sampled at the next edge (cycle 0) and runs until done or budget.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic h,
                          input logic sa, input logic sb,
                          output logic [31:0] res, output int lat, output logic busy_ok);
        a = av; b = bv; half = h; signed_a = sa; signed_b = sb; start = 1'b1;
        tick();
        start = 1'b0;
        a = 32'hDEADBEEF; b = 32'hCAFEF00D;
        lat = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin
                lat = c;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            tick();
        end
        res = result;
    endtask

    task automatic watch_no_done(input int n, input string name);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        bok;

        vecs[0]  = '{32'h00000007, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b1, 32'hFFFFFFEB};
        vecs[1]  = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE};
        vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'h00000001};
        vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h00000001};
        vecs[6]  = '{32'h00010000, 32'h00010000, 1'b1, 1'b0, 1'b0, 32'h00000001};
        vecs[7]  = '{32'h80000000, 32'h00000002, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
        vecs[8]  = '{32'h80000000, 32'h00000002, 1'b0, 1'b1, 1'b1, 32'h00000000};
        vecs[9]  = '{32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 32'h0000000F};
        vecs[10] = '{32'h00012345, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h00000000};
        vecs[11] = '{32'h00000009, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000009};

        // Reset state while rst is held
        #2;
        chk("reset_busy",   {31'd0, busy}, 32'd0);
        chk("reset_done",   {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].half, vecs[i].sa, vecs[i].sb, res, lat, bok);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].b, vecs[i].sb));
            chk($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
            tick();
            chk($sformatf("vec%0d_done_single", i), {31'd0, done}, 32'd0);
        end

        // Flush at cycle 10, restart at cycle 12 with 3*5
        a = 32'h00000007; b = 32'hFFFFFFFD; half = 1'b0; signed_a = 1'b0; signed_b = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_c11", {31'd0, busy}, 32'd0);
        chk("flush_done_c11", {31'd0, done}, 32'd0);
        chk("flush_result_held", result, vecs[NV-1].exp);
        tick();
        chk("flush_done_c12", {31'd0, done}, 32'd0);
        run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, res, lat, bok);
        chk("flush_restart_result", res, 32'd15);
        chk("flush_restart_latency", lat, exp_lat(32'd5, 1'b0));
        tick();

        // Flush and start together in IDLE
        a = 32'd4; b = 32'd4; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        watch_no_done(40, "flush_start_no_done");
        chk("flush_start_result", result, 32'd15);

        // Start while busy is ignored
        a = 32'd6; b = 32'd7; half = 1'b0; signed_a = 1'b0; signed_b = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 32'd100; b = 32'd100; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int c = 3; c <= 100; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            tick();
        end
        chk("busy_start_result", result, 32'd42);
        chk("busy_start_latency", lat, exp_lat(32'd7, 1'b0));
        watch_no_done(40, "busy_start_no_second_done");

        // Asynchronous reset in cycle 5 of CALC
        a = 32'h00001234; b = 32'hFFFFFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy",   {31'd0, busy}, 32'd0);
        chk("rst_mid_done",   {31'd0, done}, 32'd0);
        chk("rst_mid_result", result, 32'd0);
        tick();
        rst = 1'b0;
        watch_no_done(40, "rst_mid_no_done");

        // Start during DONE is ignored
        run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, res, lat, bok);
        chk("done_start_first_result", res, 32'd15);
        a = 32'd2; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_busy", {31'd0, busy}, 32'd0);
        watch_no_done(40, "done_start_no_done");
        chk("done_start_result", result, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
